// File: rtl/trig_scan_gen.sv
// Scans a time-multiplexed channel frame, picks the lowest or highest sounding tuning word,
// and advances a phase accumulator by it once per frame; the accumulator MSB is the trigger.
module trig_scan_gen #(
    parameter int unsigned NUM_BITS     = 32,
    parameter int unsigned NUM_CHANNELS = 16,
    parameter int unsigned CH_BITS      = $clog2(NUM_CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ch_valid_i,
    input  logic [CH_BITS-1:0]  ch_idx_i,
    input  logic                ch_active_i,
    input  logic [NUM_BITS-1:0] ch_tuning_i,
    input  logic                mode_i,
    output logic                trigger_o,
    output logic                trig_pulse_o,
    output logic [NUM_BITS-1:0] sel_word_o,
    output logic [CH_BITS-1:0]  sel_chan_o,
    output logic                frame_done_o,
    output logic                seq_err_o
);

    localparam logic [CH_BITS-1:0] LastIdx = CH_BITS'(NUM_CHANNELS - 1);

    typedef enum logic [0:0] {
        StScan,
        StUpdate
    } state_e;

    state_e                state_q;
    logic [CH_BITS-1:0]    exp_idx_q;
    logic                  mode_q;
    logic [NUM_BITS-1:0]   best_word_q;
    logic [CH_BITS-1:0]    best_chan_q;
    logic [NUM_BITS-1:0]   acc_q;
    logic [NUM_BITS-1:0]   sel_word_q;
    logic [CH_BITS-1:0]    sel_chan_q;
    logic                  msb_prev_q;
    logic                  trig_pulse_q;
    logic                  frame_done_q;
    logic                  seq_err_q;

    logic                  in_order;
    logic                  accept;
    logic                  seq_bad;
    logic                  last_ch;
    logic                  cur_mode;
    logic                  is_cand;
    logic                  better;
    logic                  take;
    logic [NUM_BITS-1:0]   acc_sum;

    always_comb begin
        in_order = (ch_idx_i == exp_idx_q);
        accept   = (state_q == StScan) && ch_valid_i && in_order;
        seq_bad  = (state_q == StScan) && ch_valid_i && !in_order;
        last_ch  = (exp_idx_q == LastIdx);
        // Channel 0 compares with the mode being captured in the same cycle.
        cur_mode = (exp_idx_q == '0) ? mode_i : mode_q;
        is_cand  = ch_active_i && (ch_tuning_i != '0);
        better   = cur_mode ? (ch_tuning_i > best_word_q) : (ch_tuning_i < best_word_q);
        // A zero best word doubles as "no candidate yet": candidates are never zero.
        take     = accept && is_cand && ((best_word_q == '0) || better);
        acc_sum  = acc_q + best_word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StScan;
            exp_idx_q    <= '0;
            mode_q       <= 1'b0;
            best_word_q  <= '0;
            best_chan_q  <= '0;
            acc_q        <= '0;
            sel_word_q   <= '0;
            sel_chan_q   <= '0;
            msb_prev_q   <= 1'b0;
            trig_pulse_q <= 1'b0;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            msb_prev_q   <= acc_q[NUM_BITS-1];
            trig_pulse_q <= acc_q[NUM_BITS-1] & ~msb_prev_q;
            frame_done_q <= 1'b0;
            case (state_q)
                StScan: begin
                    if (seq_bad) begin
                        seq_err_q   <= 1'b1;
                        exp_idx_q   <= '0;
                        best_word_q <= '0;
                        best_chan_q <= '0;
                    end else if (accept) begin
                        if (exp_idx_q == '0) begin
                            mode_q <= mode_i;
                        end
                        if (take) begin
                            best_word_q <= ch_tuning_i;
                            best_chan_q <= ch_idx_i;
                        end
                        if (last_ch) begin
                            exp_idx_q    <= '0;
                            state_q      <= StUpdate;
                            frame_done_q <= 1'b1;
                        end else begin
                            exp_idx_q <= exp_idx_q + CH_BITS'(1);
                        end
                    end
                end
                StUpdate: begin
                    sel_word_q  <= best_word_q;
                    sel_chan_q  <= best_chan_q;
                    acc_q       <= (best_word_q != '0) ? acc_sum : '0;
                    best_word_q <= '0;
                    best_chan_q <= '0;
                    state_q     <= StScan;
                end
                default: state_q <= StScan;
            endcase
        end
    end

    assign trigger_o    = acc_q[NUM_BITS-1];
    assign trig_pulse_o = trig_pulse_q;
    assign sel_word_o   = sel_word_q;
    assign sel_chan_o   = sel_chan_q;
    assign frame_done_o = frame_done_q;
    assign seq_err_o    = seq_err_q;

endmodule

// File: tb/tb_trig_scan_gen.sv
// Randomised and directed bench for trig_scan_gen (4 channels, 16-bit words) against a
// frame-level reference model of selection and accumulation.
module tb_trig_scan_gen;

    localparam int NB  = 16;
    localparam int NCH = 4;
    localparam int CB  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ch_valid;
    logic [CB-1:0] ch_idx;
    logic          ch_active;
    logic [NB-1:0] ch_tuning;
    logic          mode;
    logic          trigger;
    logic          trig_pulse;
    logic [NB-1:0] sel_word;
    logic [CB-1:0] sel_chan;
    logic          frame_done;
    logic          seq_err;

    trig_scan_gen #(
        .NUM_BITS    (NB),
        .NUM_CHANNELS(NCH),
        .CH_BITS     (CB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_valid_i  (ch_valid),
        .ch_idx_i    (ch_idx),
        .ch_active_i (ch_active),
        .ch_tuning_i (ch_tuning),
        .mode_i      (mode),
        .trigger_o   (trigger),
        .trig_pulse_o(trig_pulse),
        .sel_word_o  (sel_word),
        .sel_chan_o  (sel_chan),
        .frame_done_o(frame_done),
        .seq_err_o   (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          fd;
        logic [NB-1:0] word;
        logic [CB-1:0] chan;
        logic [NB-1:0] acc;
        logic          trig;
        logic          fd_after;
        logic          pulse;
        logic          err;
    } obs_t;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [NB-1:0] m_acc;
    logic          m_seq_err;

    function automatic string fmt(obs_t o);
        return $sformatf("fd=%b word=%h chan=%0d acc=%h trig=%b fd_after=%b pulse=%b err=%b",
                         o.fd, o.word, o.chan, o.acc, o.trig, o.fd_after, o.pulse, o.err);
    endfunction

    // Selection rule: extreme value among sounding nonzero words, lowest index on ties.
    task automatic ref_select(input logic [NCH-1:0][NB-1:0] w, input logic [NCH-1:0] a,
                              input logic md, output logic [NB-1:0] bw, output logic [CB-1:0] bc);
        logic [NB-1:0] ext;
        bit            found;
        found = 0;
        ext   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (a[i] && w[i] != 0) begin
                if (!found) ext = w[i];
                else if (md ? (w[i] > ext) : (w[i] < ext)) ext = w[i];
                found = 1;
            end
        end
        bw = ext;
        bc = '0;
        if (found) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (a[i] && w[i] == ext) bc = CB'(i);
            end
        end
    endtask

    task automatic model_reset();
        m_acc     = '0;
        m_seq_err = 1'b0;
    endtask

    task automatic model_frame(input logic [NCH-1:0][NB-1:0] w, input logic [NCH-1:0] a,
                               input logic md, output obs_t e);
        logic [NB-1:0] bw;
        logic [CB-1:0] bc;
        logic          old_msb;
        ref_select(w, a, md, bw, bc);
        old_msb    = m_acc[NB-1];
        m_acc      = (bw != 0) ? m_acc + bw : '0;
        e.fd       = 1'b1;
        e.word     = bw;
        e.chan     = bc;
        e.acc      = m_acc;
        e.trig     = m_acc[NB-1];
        e.fd_after = 1'b0;
        e.pulse    = !old_msb && m_acc[NB-1];
        e.err      = m_seq_err;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ch_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    // Present channels 0..NCH-1 on consecutive cycles, then the update cycle and two idle cycles.
    task automatic drive_frame(input logic [NCH-1:0][NB-1:0] w, input logic [NCH-1:0] a,
                               input logic md_first, input logic md_rest, input logic gap_valid,
                               output obs_t o);
        for (int i = 0; i < NCH; i++) begin
            ch_valid  = 1'b1;
            ch_idx    = CB'(i);
            ch_active = a[i];
            ch_tuning = w[i];
            mode      = (i == 0) ? md_first : md_rest;
            step();
        end
        ch_valid  = gap_valid;
        ch_idx    = CB'($urandom_range(0, NCH - 1));
        ch_active = 1'b1;
        ch_tuning = NB'($urandom);
        mode      = 1'($urandom_range(0, 1));
        @(negedge clk);
        o.fd = frame_done;
        step();
        ch_valid = 1'b0;
        @(negedge clk);
        o.word     = sel_word;
        o.chan     = sel_chan;
        o.acc      = dut.acc_q;
        o.trig     = trigger;
        o.fd_after = frame_done;
        o.err      = seq_err;
        step();
        @(negedge clk);
        o.pulse = trig_pulse;
        step();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        ch_valid  = 1'b0;
        ch_idx    = '0;
        ch_active = 1'b0;
        ch_tuning = '0;
        mode      = 1'b0;
        step();
        @(negedge clk);
        vectors++; if (sel_word !== '0) begin miscompares++; $display("FAIL reset sel_word got %h want 0", sel_word); end
        vectors++; if (sel_chan !== '0) begin miscompares++; $display("FAIL reset sel_chan got %0d want 0", sel_chan); end
        vectors++; if (trigger !== 1'b0) begin miscompares++; $display("FAIL reset trigger got %b want 0", trigger); end
        vectors++; if (trig_pulse !== 1'b0) begin miscompares++; $display("FAIL reset trig_pulse got %b want 0", trig_pulse); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset frame_done got %b want 0", frame_done); end
        vectors++; if (seq_err !== 1'b0) begin miscompares++; $display("FAIL reset seq_err got %b want 0", seq_err); end
        vectors++; if (dut.acc_q !== '0) begin miscompares++; $display("FAIL reset acc got %h want 0", dut.acc_q); end
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_min_select();
        logic [NCH-1:0][NB-1:0] w;
        logic [NCH-1:0]         a;
        obs_t                   o, e;
        w = '0;
        w[0] = 16'd300; w[1] = 16'd100; w[2] = 16'd50; w[3] = 16'd0;
        a = 4'b1011;
        for (int f = 0; f < 2; f++) begin
            drive_frame(w, a, 1'b0, 1'b0, 1'b0, o);
            model_frame(w, a, 1'b0, e);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL min_select frame %0d: got %s want %s", f, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_max_capture();
        logic [NCH-1:0][NB-1:0] w;
        logic [NCH-1:0]         a;
        logic [1:0]             modes [3];
        obs_t                   o, e;
        w = '0;
        w[0] = 16'd300; w[1] = 16'd100; w[2] = 16'd50; w[3] = 16'd0;
        a = 4'b1011;
        modes = '{2'b11, 2'b10, 2'b01};  // {mode at channel 0, mode afterwards}
        for (int f = 0; f < 3; f++) begin
            drive_frame(w, a, modes[f][1], modes[f][0], 1'b0, o);
            model_frame(w, a, modes[f][1], e);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL max_capture frame %0d: got %s want %s", f, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_tie();
        logic [NCH-1:0][NB-1:0] w;
        logic [NCH-1:0]         a;
        obs_t                   o, e;
        for (int md = 0; md < 2; md++) begin
            w = '0;
            w[0] = (md == 0) ? 16'h2000 : 16'h0010;
            w[1] = 16'h1000; w[2] = 16'h0000; w[3] = 16'h1000;
            a = 4'b1111;
            drive_frame(w, a, 1'(md), 1'(md), 1'b0, o);
            model_frame(w, a, 1'(md), e);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL tie mode %0d: got %s want %s", md, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_wrap();
        logic [NCH-1:0][NB-1:0] w;
        logic [NCH-1:0]         a;
        obs_t                   o, e;
        do_reset();
        w = '0;
        w[2] = 16'h4000;
        for (int f = 0; f < 5; f++) begin
            a = (f < 4) ? 4'b0100 : 4'b0000;
            drive_frame(w, a, 1'b0, 1'b0, 1'b0, o);
            model_frame(w, a, 1'b0, e);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL wrap frame %0d: got %s want %s", f, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0][NB-1:0] w;
        logic [NCH-1:0]         a;
        logic                   m0, m1, gv;
        obs_t                   o, e;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 3) == 0) w[i] = '0;
                else if ($urandom_range(0, 1) == 1) w[i] = NB'($urandom_range(1, 6));
                else w[i] = NB'($urandom);
                a[i] = 1'($urandom_range(0, 3) != 0);
            end
            m0 = 1'($urandom_range(0, 1));
            m1 = 1'($urandom_range(0, 1));
            gv = 1'($urandom_range(0, 1));
            drive_frame(w, a, m0, m1, gv, o);
            model_frame(w, a, m0, e);
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL random frame %0d: got %s want %s", f, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_seq_err();
        logic [NCH-1:0][NB-1:0] w;
        logic [NCH-1:0]         a;
        logic [CB-1:0]          order [3];
        logic                   fd_seen;
        obs_t                   o, e;
        order   = '{2'd0, 2'd1, 2'd3};
        fd_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ch_valid  = 1'b1;
            ch_idx    = order[i];
            ch_active = 1'b1;
            ch_tuning = 16'h0100;
            mode      = 1'b0;
            @(negedge clk);
            fd_seen |= frame_done;
            step();
        end
        ch_valid = 1'b0;
        m_seq_err = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            fd_seen |= frame_done;
            step();
        end
        vectors++; if (seq_err !== 1'b1) begin miscompares++; $display("FAIL seq_err flag got %b want 1", seq_err); end
        vectors++; if (fd_seen !== 1'b0) begin miscompares++; $display("FAIL seq_err frame_done got %b want 0", fd_seen); end
        w = '0;
        w[0] = 16'h0700; w[1] = 16'h0300; w[2] = 16'h0500; w[3] = 16'h0900;
        a = 4'b1101;
        drive_frame(w, a, 1'b0, 1'b0, 1'b0, o);
        model_frame(w, a, 1'b0, e);
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL seq_err recovery: got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_reset_mid();
        logic [NCH-1:0][NB-1:0] w;
        logic [NCH-1:0]         a;
        logic [NB+CB+3:0]       outs;
        obs_t                   o, e;
        for (int i = 0; i < 3; i++) begin
            ch_valid  = 1'b1;
            ch_idx    = CB'(i);
            ch_active = 1'b1;
            ch_tuning = NB'(16'h0040 + i);
            mode      = 1'b0;
            step();
        end
        rst      = 1'b1;
        ch_valid = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        outs = {sel_word, sel_chan, trigger, trig_pulse, frame_done, seq_err};
        vectors++;
        if (outs !== '0) begin miscompares++; $display("FAIL reset_mid outputs got %h want 0", outs); end
        w = '0;
        w[0] = 16'h9000; w[1] = 16'h8800; w[2] = 16'h0000; w[3] = 16'hA000;
        a = 4'b1111;
        drive_frame(w, a, 1'b1, 1'b1, 1'b0, o);
        model_frame(w, a, 1'b1, e);
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL reset_mid first frame: got %s want %s", fmt(o), fmt(e)); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_min_select();
        test_max_capture();
        test_tie();
        test_wrap();
        test_random();
        test_seq_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trig_scan_gen.md
TRIG_SCAN_GEN -- requirements
Module: trig_scan_gen

Interface
REQ-001 Parameter NUM_BITS, default 32, width of tuning words and of the phase accumulator.
REQ-002 Parameter NUM_CHANNELS, default 16, number of time-multiplexed channels per frame; legal range 2..256.
REQ-003 Parameter CH_BITS, default $clog2(NUM_CHANNELS), width of channel index signals.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ch_valid  in  1  current channel sample is present this cycle.
REQ-007 ch_idx  in  CH_BITS  index of presented channel.
REQ-008 ch_active  in  1  presented channel holds a sounding note.
REQ-009 ch_tuning  in  NUM_BITS  unsigned tuning word of presented channel.
REQ-010 mode  in  1  selection rule: 0 = lowest nonzero word, 1 = highest word.
REQ-011 trigger  out  1  accumulator MSB (square wave at selected pitch / frame rate).
REQ-012 trig_pulse  out  1  one-cycle pulse on each 0->1 transition of trigger.
REQ-013 sel_word  out  NUM_BITS  word applied in the most recent update.
REQ-014 sel_chan  out  CH_BITS  channel that supplied sel_word; 0 when sel_word = 0.
REQ-015 frame_done  out  1  one-cycle pulse in the cycle the update occurs.
REQ-016 seq_err  out  1  sticky flag: out-of-order channel index detected.

Function
REQ-017 Two-state FSM: S_SCAN (collect candidates), S_UPDATE (apply result, one cycle, returns to S_SCAN).
REQ-018 In S_SCAN a sample is accepted only when ch_valid=1 and ch_idx equals internal expected index exp_idx.
REQ-019 exp_idx increments by 1 per accepted sample; accepting index NUM_CHANNELS-1 sets exp_idx to 0 and moves FSM to S_UPDATE.
REQ-020 ch_valid=1 with ch_idx != exp_idx sets seq_err, discards the sample and partial frame, resets candidate, sets exp_idx to 0; no update occurs.
REQ-021 ch_valid in S_UPDATE is ignored (upstream inserts a one-cycle gap after the last channel); it does not set seq_err.
REQ-022 mode is captured when channel 0 is accepted and held for the whole frame; mid-frame changes affect the next frame only.
REQ-023 A sample is a candidate only if ch_active=1 and ch_tuning != 0.
REQ-024 Mode 0: candidate replaces best if no best yet or ch_tuning < best (strict); equal words keep the lower index.
REQ-025 Mode 1: candidate replaces best if no best yet or ch_tuning > best (strict); equal words keep the lower index.
REQ-026 In S_UPDATE: sel_word <= best (0 if no candidate), sel_chan <= best channel (0 if none), frame_done = 1, best cleared.
REQ-027 In S_UPDATE with candidate: acc <= acc + best, modulo 2^NUM_BITS (wrap, no saturation).
REQ-028 In S_UPDATE with no candidate: acc <= 0 (trigger falls low, silence).
REQ-029 acc changes only in S_UPDATE; trigger = acc[NUM_BITS-1] combinationally.
REQ-030 trig_pulse registered: high one cycle after the cycle where acc MSB changed 0->1; never for 1->0.
REQ-031 Sample at index NUM_CHANNELS-1 participates in selection of the same frame's update.

Reset
REQ-032 rst=1 forces: FSM S_SCAN, exp_idx 0, best cleared, acc 0, sel_word 0, sel_chan 0, trigger 0, trig_pulse 0, frame_done 0, seq_err 0, captured mode 0.
REQ-033 Reset asserted mid-frame discards the partial frame; first frame after release starts at channel 0.
REQ-034 seq_err clears only on rst.

Verification
REQ-035 NUM_CHANNELS=4, mode 0, words {0:300 act, 1:100 act, 2:50 inactive, 3:0 act} -> sel_word=100, sel_chan=1, acc=100 after frame 1, 200 after frame 2.
REQ-036 Same frame, mode 1 -> sel_word=300, sel_chan=0; mode toggled after channel 0 accepted -> current frame still uses captured mode.
REQ-037 Tie: channels 1 and 3 both 0x1000 active, mode 0 -> sel_chan=1.
REQ-038 NUM_BITS=8, selected word 0x40 repeated -> acc 0x40,0x80 (trig_pulse one cycle after),0xC0,0x00 (wrap, trigger low); no active channels next frame -> acc 0.
REQ-039 Indices 0,1,3 presented -> seq_err=1, no frame_done; subsequent clean 0..3 frame updates normally.
REQ-040 rst asserted after channel 2 accepted -> all outputs 0 next cycle; following full frame produces correct first update.
